// File: rtl/axi_lite_mem_link.sv
// AXI4-Lite master plus a 16-word AXI4-Lite slave memory on one internal bus.
// A user command (start/mode/addr/wdata_in) runs one single-beat read or write.
// The internal AW/W/B/AR/R handshakes are exported so they can be monitored.
module axi_lite_mem_link #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [DATA_W-1:0] rdata_out,
    output logic              done,
    output logic              busy,
    output logic              awvalid,
    output logic              awready,
    output logic              wvalid,
    output logic              wready,
    output logic              bvalid,
    output logic              bready,
    output logic              arvalid,
    output logic              arready,
    output logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [ADDR_W-1:0] araddr,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWresp,
        StRaddr,
        StRdata,
        StDone
    } state_e;

    state_e state_q;

    logic aw_fire;
    logic w_fire;
    logic b_fire;
    logic ar_fire;
    logic r_fire;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign b_fire  = bvalid && bready;
    assign ar_fire = arvalid && arready;
    assign r_fire  = rvalid && rready;

    // Slave-side state
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic              aw_held_q;
    logic              w_held_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] w_data_q;

    logic              aw_have;
    logic              w_have;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    // Write commits on the edge where the later of AW/W lands, so the common
    // simultaneous case raises bvalid one edge after the handshakes.
    assign aw_have = aw_held_q || aw_fire;
    assign w_have  = w_held_q || w_fire;
    assign wr_idx  = aw_fire ? awaddr[IDX_W+1:2] : aw_idx_q;
    assign wr_data = w_fire ? wdata : w_data_q;

    // Master FSM: issues one transaction per accepted start, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            rdata_out <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (mode) begin
                            awaddr  <= addr;
                            wdata   <= wdata_in;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state_q <= StWaddr;
                        end else begin
                            araddr  <= addr;
                            arvalid <= 1'b1;
                            state_q <= StRaddr;
                        end
                    end
                end
                StWaddr: begin
                    if (aw_fire) awvalid <= 1'b0;
                    if (w_fire) wvalid <= 1'b0;
                    // A channel whose valid is already low has completed earlier
                    if ((!awvalid || aw_fire) && (!wvalid || w_fire)) begin
                        bready  <= 1'b1;
                        state_q <= StWresp;
                    end
                end
                StWresp: begin
                    if (b_fire) begin
                        bready  <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StRaddr: begin
                    if (ar_fire) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= StRdata;
                    end
                end
                StRdata: begin
                    if (r_fire) begin
                        rready    <= 1'b0;
                        rdata_out <= rdata;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Slave write path: single-cycle readies, latch AW/W, commit and respond on B
    always_ff @(posedge clk) begin
        if (rst) begin
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            awready <= awvalid && !awready && !aw_held_q;
            wready  <= wvalid && !wready && !w_held_q;
            if (aw_fire) aw_idx_q <= awaddr[IDX_W+1:2];
            if (w_fire) w_data_q <= wdata;
            if (b_fire) bvalid <= 1'b0;
            if (aw_have && w_have) begin
                mem[wr_idx] <= wr_data;
                bvalid      <= 1'b1;
                aw_held_q   <= 1'b0;
                w_held_q    <= 1'b0;
            end else begin
                if (aw_fire) aw_held_q <= 1'b1;
                if (w_fire) w_held_q <= 1'b1;
            end
        end
    end

    // Slave read path: single-cycle arready, data captured on AR, held until R
    always_ff @(posedge clk) begin
        if (rst) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            arready <= arvalid && !arready && !rvalid;
            if (ar_fire) begin
                rdata  <= mem[araddr[IDX_W+1:2]];
                rvalid <= 1'b1;
            end else if (r_fire) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_link.sv
// Self-checking bench for axi_lite_mem_link: directed scenarios plus random
// reads/writes against an array model of the 16-word memory.
module tb_axi_lite_mem_link;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic [31:0] rdata_out;
    logic        done;
    logic        busy;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, araddr, wdata, rdata;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_mem [16];
    logic [31:0] exp_rdata;

    axi_lite_mem_link #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MEM_DEPTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .addr     (addr),
        .wdata_in (wdata_in),
        .rdata_out(rdata_out),
        .done     (done),
        .busy     (busy),
        .awvalid  (awvalid),
        .awready  (awready),
        .wvalid   (wvalid),
        .wready   (wready),
        .bvalid   (bvalid),
        .bready   (bready),
        .arvalid  (arvalid),
        .arready  (arready),
        .rvalid   (rvalid),
        .rready   (rready),
        .awaddr   (awaddr),
        .araddr   (araddr),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("%s mem[%0d]", tag, i), dut.mem[i], exp_mem[i]);
        end
    endtask

    function automatic int word_idx(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    // One command. Edges are counted from E0 (the edge that samples start);
    // observation k is taken just before edge E_k, so a handshake seen there
    // completes at E_k and a level seen there holds between E_(k-1) and E_k.
    task automatic txn(input logic m, input logic [31:0] a, input logic [31:0] d,
                       input bit pulse_start, input bit do_rst, input string tag);
        int aw_k, w_k, b_k, ar_k, r_k, done_k, done_cnt, busy_low_k;
        logic [31:0] aw_a, w_d, ar_a, r_d;
        aw_k = 0; w_k = 0; b_k = 0; ar_k = 0; r_k = 0;
        done_k = 0; done_cnt = 0; busy_low_k = 0;
        aw_a = '0; w_d = '0; ar_a = '0; r_d = '0;

        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        addr     = a;
        wdata_in = d;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (awvalid && awready) begin aw_k = k; aw_a = awaddr; end
            if (wvalid && wready) begin w_k = k; w_d = wdata; end
            if (bvalid && bready) b_k = k;
            if (arvalid && arready) begin ar_k = k; ar_a = araddr; end
            if (rvalid && rready) begin r_k = k; r_d = rdata; end
            if (done) begin done_cnt++; done_k = k; end
            if (!busy && busy_low_k == 0) busy_low_k = k;
            if (k == 1) begin
                start = 1'b0;
                if (do_rst) rst = 1'b1;
            end
            if (k == 2) begin
                rst = 1'b0;
                if (pulse_start) begin
                    start    = 1'b1;
                    mode     = 1'b1;
                    addr     = 32'h8;
                    wdata_in = 32'hBADBAD00;
                end
            end
            if (k == 3) start = 1'b0;
        end

        if (do_rst) begin
            check_eq({tag, " no B"}, b_k, 0);
            check_eq({tag, " no done"}, done_cnt, 0);
            for (int i = 0; i < 16; i++) exp_mem[i] = '0;
            exp_rdata = '0;
        end else begin
            check_eq({tag, " done count"}, done_cnt, 1);
            check_eq({tag, " done edge"}, done_k, 4);
            check_eq({tag, " busy low"}, busy_low_k, 5);
            if (m) begin
                check_eq({tag, " AW edge"}, aw_k, 2);
                check_eq({tag, " W edge"}, w_k, 2);
                check_eq({tag, " B edge"}, b_k, 3);
                check_eq({tag, " awaddr"}, aw_a, a);
                check_eq({tag, " wdata"}, w_d, d);
                exp_mem[word_idx(a)] = d;
            end else begin
                check_eq({tag, " AR edge"}, ar_k, 2);
                check_eq({tag, " R edge"}, r_k, 3);
                check_eq({tag, " araddr"}, ar_a, a);
                check_eq({tag, " rdata"}, r_d, exp_mem[word_idx(a)]);
                exp_rdata = exp_mem[word_idx(a)];
            end
        end
        check_eq({tag, " rdata_out"}, rdata_out, exp_rdata);
    endtask

    initial begin
        logic        rm;
        logic [31:0] ra;
        logic [31:0] rd;
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        addr     = '0;
        wdata_in = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = '0;
        exp_rdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset done", done, 0);
        check_eq("reset busy", busy, 0);
        check_eq("reset rdata_out", rdata_out, 0);
        check_eq("reset valids", {awvalid, wvalid, bvalid, arvalid, rvalid}, 0);
        check_eq("reset readies", {awready, wready, bready, arready, rready}, 0);
        check_mem("reset");

        txn(1'b1, 32'h10, 32'hDEADBAAD, 1'b0, 1'b0, "wr 0x10");
        check_mem("after wr 0x10");
        txn(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, "rd 0x10");

        txn(1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0, "wr 0x40 wrap");
        txn(1'b0, 32'h00, 32'h0, 1'b0, 1'b0, "rd 0x00");
        check_mem("after wrap");

        txn(1'b1, 32'h20, 32'h0F0F1234, 1'b1, 1'b0, "wr while busy");
        check_eq("ignored start mem[2]", dut.mem[2], 32'h0);
        check_mem("after ignored start");

        txn(1'b1, 32'h14, 32'hCAFEF00D, 1'b0, 1'b1, "rst mid wr");
        check_eq("rst mem[5]", dut.mem[5], 32'h0);
        check_mem("after rst");
        txn(1'b0, 32'h14, 32'h0, 1'b0, 1'b0, "rd 0x14 after rst");

        txn(1'b1, 32'h3C, 32'hA5A5A5A5, 1'b0, 1'b0, "wr 0x3C");
        txn(1'b0, 32'h3C, 32'h0, 1'b0, 1'b0, "rd 0x3C");
        check_eq("mem[15]", dut.mem[15], 32'hA5A5A5A5);

        for (int n = 0; n < 40; n++) begin
            rm = 1'($urandom_range(0, 1));
            ra = $urandom;
            rd = $urandom;
            txn(rm, ra, rd, 1'b0, 1'b0, $sformatf("rand%0d", n));
        end
        check_mem("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
